// File: rtl/io_input_feeder.sv
// io_input_feeder
//   Buffers words offered by an external device in a small circular FIFO and
//   hands them one at a time to the Memory Input port using a
//   present / acknowledge / clear handshake.
//
// Ports
//   Clk, RstN      clock (rising edge) and asynchronous active-low reset
//   DevData        word offered by the device
//   DevValid       device offers DevData this cycle
//   DevReady       FIFO can accept a word (combinational, from registered Count)
//   Input          registered word presented to Memory
//   InputRecv      Memory reports that the CPU has read the presented word
//   InputRst       registered one-cycle pulse clearing InputRecv in Memory
//   Pending        a word is presented on Input and not yet consumed
//   Count          words held in the FIFO, excluding the presented word
//   Overflow       sticky: a word was offered while DevReady was low
//   ClrOvf         synchronous clear of Overflow
module io_input_feeder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         RstN,
  input  logic [WIDTH-1:0]             DevData,
  input  logic                         DevValid,
  output logic                         DevReady,
  output logic [WIDTH-1:0]             Input,
  input  logic                         InputRecv,
  output logic                         InputRst,
  output logic                         Pending,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow,
  input  logic                         ClrOvf
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRESENT  = 2'd1;
  localparam logic [1:0] S_ACK      = 2'd2;
  localparam logic [1:0] S_WAIT_CLR = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] input_q, input_d;
  logic             pending_q, pending_d;
  logic             input_rst_q, input_rst_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic dev_ready;
  logic push;
  logic pop;

  // DevReady comes from the registered count only, so a pop on the same edge
  // never opens a slot for a push while full.
  assign dev_ready = (count_q != CW'(DEPTH));
  assign push      = DevValid && dev_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  // Storage; a push never targets the head slot being popped because the
  // FIFO is not full whenever a push is accepted.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[tail_q] <= DevData;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A fresh overflow wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ClrOvf) begin
      ovf_d = 1'b0;
    end
    if (DevValid && !dev_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    input_d     = input_q;
    pending_d   = pending_q;
    input_rst_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          input_d   = mem_q[head_q];
          pending_d = 1'b1;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (InputRecv) begin
          pending_d   = 1'b0;
          input_rst_d = 1'b1;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!InputRecv) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= S_IDLE;
      input_q     <= '0;
      pending_q   <= 1'b0;
      input_rst_q <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      input_q     <= input_d;
      pending_q   <= pending_d;
      input_rst_q <= input_rst_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign DevReady = dev_ready;
  assign Input    = input_q;
  assign InputRst = input_rst_q;
  assign Pending  = pending_q;
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_io_input_feeder.sv
// tb_io_input_feeder
//   Directed bench for io_input_feeder. Words expected on Input are queued
//   when pushed; a monitor pops and compares them as each word is presented.
module tb_io_input_feeder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             Clk;
  logic             RstN;
  logic [WIDTH-1:0] DevData;
  logic             DevValid;
  logic             DevReady;
  logic [WIDTH-1:0] Input;
  logic             InputRecv;
  logic             InputRst;
  logic             Pending;
  logic [2:0]       Count;
  logic             Overflow;
  logic             ClrOvf;

  int unsigned checks;
  int unsigned errors;

  logic [WIDTH-1:0] exp_q [$];

  logic man_recv;
  logic recv_q;
  logic ack_en;

  assign InputRecv = man_recv | recv_q;

  io_input_feeder #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .DevData  (DevData),
    .DevValid (DevValid),
    .DevReady (DevReady),
    .Input    (Input),
    .InputRecv(InputRecv),
    .InputRst (InputRst),
    .Pending  (Pending),
    .Count    (Count),
    .Overflow (Overflow),
    .ClrOvf   (ClrOvf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Memory model: raises InputRecv once a word is pending (when enabled) and
  // drops it when the feeder pulses InputRst.
  initial begin
    recv_q = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (InputRst) recv_q = 1'b0;
      else if (ack_en && Pending) recv_q = 1'b1;
    end
  end

  // Monitor: checks each presented word against the scoreboard, Input
  // stability while pending, and single-cycle InputRst pulses.
  initial begin
    logic             prev_pend;
    logic             prev_rst;
    logic [WIDTH-1:0] prev_input;
    logic [WIDTH-1:0] e;
    prev_pend  = 1'b0;
    prev_rst   = 1'b0;
    prev_input = '0;
    forever begin
      @(negedge Clk);
      if (Pending && !prev_pend) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL presented_word: got %0h expected no word", Input);
        end else begin
          e = exp_q.pop_front();
          if (Input !== e) begin
            errors++;
            $display("FAIL presented_word: got %0h expected %0h", Input, e);
          end
        end
      end
      if (Pending && prev_pend) begin
        checks++;
        if (Input !== prev_input) begin
          errors++;
          $display("FAIL input_stable: got %0h expected %0h", Input, prev_input);
        end
      end
      if (InputRst && prev_rst) begin
        checks++;
        errors++;
        $display("FAIL input_rst_width: got 2+ cycles expected 1");
      end
      prev_pend  = Pending;
      prev_rst   = InputRst;
      prev_input = Input;
    end
  end

  task automatic wait_idle(input int unsigned budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < int'(budget); n++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && Count == 0 && !Pending && !InputRst && !InputRecv) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
    step();
    step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RstN     = 1'b1;
    DevData  = '0;
    DevValid = 1'b0;
    ClrOvf   = 1'b0;
    man_recv = 1'b0;
    ack_en   = 1'b0;

    // Reset values
    #2 RstN = 1'b0;
    #1;
    chk("rst_input",    Input,    0);
    chk("rst_pending",  Pending,  0);
    chk("rst_inputrst", InputRst, 0);
    chk("rst_count",    Count,    0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_devready", DevReady, 1);
    @(negedge Clk);
    @(negedge Clk);
    RstN = 1'b1;
    step();
    chk("post_rst_devready", DevReady, 1);

    // Single word: presented one edge after the push, acknowledged later
    DevValid = 1'b1;
    DevData  = 16'h1234;
    exp_q.push_back(16'h1234);
    step();                                 // edge N
    DevValid = 1'b0;
    @(negedge Clk);
    chk("single_count_n",   Count,   1);
    chk("single_pending_n", Pending, 0);
    step();                                 // edge N+1
    @(negedge Clk);
    chk("single_count_n1",   Count,   0);
    chk("single_pending_n1", Pending, 1);
    step();                                 // N+2
    step();                                 // N+3
    man_recv = 1'b1;
    step();                                 // N+4
    @(negedge Clk);
    chk("single_inputrst_hi", InputRst, 1);
    chk("single_pending_ack", Pending,  0);
    step();                                 // N+5
    @(negedge Clk);
    chk("single_inputrst_lo", InputRst, 0);

    // Fill while InputRecv is still held (FSM parked in WAIT_CLR)
    for (int i = 0; i < 5; i++) begin
      DevValid = 1'b1;
      DevData  = 16'hA001 + 16'(i);
      if (i < 4) exp_q.push_back(16'hA001 + 16'(i));
      step();
    end
    DevValid = 1'b0;
    @(negedge Clk);
    chk("fill_count",    Count,    4);
    chk("fill_devready", DevReady, 0);
    chk("fill_overflow", Overflow, 1);
    chk("fill_pending",  Pending,  0);

    // Clear and new overflow in the same cycle: overflow wins
    DevValid = 1'b1;
    DevData  = 16'hBEEF;
    ClrOvf   = 1'b1;
    step();
    DevValid = 1'b0;
    @(negedge Clk);
    chk("clr_vs_ovf", Overflow, 1);
    chk("clr_vs_ovf_count", Count, 4);
    step();
    ClrOvf = 1'b0;
    @(negedge Clk);
    chk("clrovf", Overflow, 0);

    // Release InputRecv; offer a word on the pop edge while full
    man_recv = 1'b0;
    step();                                 // WAIT_CLR -> IDLE
    DevValid = 1'b1;
    DevData  = 16'hBAD0;
    step();                                 // pop A001, BAD0 dropped
    DevValid = 1'b0;
    @(negedge Clk);
    chk("full_pop_count",    Count,    3);
    chk("full_pop_devready", DevReady, 1);
    chk("full_pop_overflow", Overflow, 1);
    chk("full_pop_pending",  Pending,  1);
    ClrOvf = 1'b1;
    step();
    ClrOvf = 1'b0;
    @(negedge Clk);
    chk("clrovf2", Overflow, 0);

    // Drain A001..A004 in order
    ack_en = 1'b1;
    wait_idle(200);
    chk("drain_count",   Count,   0);
    chk("drain_pending", Pending, 0);

    // Wrap: ten words through a four-entry FIFO
    for (int i = 0; i < 10; i++) begin
      for (int n = 0; n < 50 && !DevReady; n++) step();
      chk("wrap_devready", DevReady, 1);
      DevValid = 1'b1;
      DevData  = 16'(i);
      exp_q.push_back(16'(i));
      step();
      DevValid = 1'b0;
      step();
      step();
    end
    wait_idle(300);
    chk("wrap_overflow", Overflow, 0);
    chk("wrap_count",    Count,    0);

    // Stray InputRecv while empty and idle
    ack_en   = 1'b0;
    man_recv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge Clk);
      chk("stray_inputrst", InputRst, 0);
      chk("stray_pending",  Pending,  0);
    end
    man_recv = 1'b0;
    step();
    step();
    // FSM must still be in IDLE: one-edge presentation latency
    DevValid = 1'b1;
    DevData  = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    step();
    DevValid = 1'b0;
    @(negedge Clk);
    chk("stray_lat_n", Pending, 0);
    step();
    @(negedge Clk);
    chk("stray_lat_n1", Pending, 1);
    ack_en = 1'b1;
    wait_idle(100);

    // Reset mid-flight: one presented, three buffered
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      DevValid = 1'b1;
      DevData  = 16'hC001 + 16'(i);
      if (i == 0) exp_q.push_back(16'hC001);
      step();
    end
    DevValid = 1'b0;
    @(negedge Clk);
    chk("mid_pending", Pending, 1);
    chk("mid_count",   Count,   3);
    #2 RstN = 1'b0;
    #1;
    chk("midrst_input",    Input,    0);
    chk("midrst_pending",  Pending,  0);
    chk("midrst_count",    Count,    0);
    chk("midrst_inputrst", InputRst, 0);
    chk("midrst_devready", DevReady, 1);
    @(negedge Clk);
    RstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge Clk);
      chk("post_midrst_inputrst", InputRst, 0);
      chk("post_midrst_pending",  Pending,  0);
      chk("post_midrst_count",    Count,    0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
